uart_rx_frame_check: RTL and testbench

- Serial-accumulating receive-frame checker for the UART RX path. It sits between the bit sampler and the RX FIFO/ALU command decoder.
- It takes one sampled bit per strobe after start-bit detection and assembles a 5..DATA_MAX-bit data word, LSB first.
- It checks optional parity (even/odd/mark/space) and one or two stop bits.
- It reports per-frame error pulses, sticky error flags and saturating error counters.

---
 rtl/uart_rx_frame_check_if.sv | 36 +++
 rtl/uart_rx_frame_check.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_check_if.sv
// Bit-sampler / frame-checker bundle for the UART RX path.
interface uart_rx_frame_check_if #(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CNT_W    = 8
);
  logic                start_det;
  logic                bit_stb;
  logic                sampled_bit;
  logic                par_en;
  logic [1:0]          par_mode;
  logic [LEN_W-1:0]    data_len;
  logic                stop2;
  logic                err_clr;
  logic [DATA_MAX-1:0] rx_data;
  logic                rx_valid;
  logic                par_err;
  logic                stop_err;
  logic                sticky_par_err;
  logic                sticky_stop_err;
  logic [CNT_W-1:0]    par_err_cnt;
  logic [CNT_W-1:0]    stop_err_cnt;
  logic                busy;

  modport master (
    output start_det, bit_stb, sampled_bit, par_en, par_mode, data_len, stop2, err_clr,
    input  rx_data, rx_valid, par_err, stop_err, sticky_par_err, sticky_stop_err,
           par_err_cnt, stop_err_cnt, busy
  );

  modport slave (
    input  start_det, bit_stb, sampled_bit, par_en, par_mode, data_len, stop2, err_clr,
    output rx_data, rx_valid, par_err, stop_err, sticky_par_err, sticky_stop_err,
           par_err_cnt, stop_err_cnt, busy
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: assembles LSB-first data, checks parity and stop bits,
// and keeps per-frame error pulses, sticky flags and saturating error counters.
module uart_rx_frame_check #(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CNT_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_frame_check_if.slave bus
);
  localparam int unsigned BCW     = $clog2(DATA_MAX + 1);
  localparam int unsigned LEN_MIN = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [BCW-1:0]      cnt_q, cnt_d;
  logic [BCW-1:0]      len_q, len_d;
  logic                par_en_q, par_en_d;
  logic [1:0]          par_mode_q, par_mode_d;
  logic                stop2_q, stop2_d;
  logic                acc_q, acc_d;
  logic                par_bad_q, par_bad_d;
  logic                stop_bad_q, stop_bad_d;
  logic [DATA_MAX-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                par_err_q, par_err_d;
  logic                stop_err_q, stop_err_d;
  logic                sticky_par_q, sticky_par_d;
  logic                sticky_stop_q, sticky_stop_d;
  logic [CNT_W-1:0]    par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic                busy_q, busy_d;
  logic [BCW-1:0]      eff_len_c;
  logic                exp_par_c;
  logic                last_stop_c;

  // Error counter update: a coincident error outranks the clear.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic ev, input logic clr);
    if (clr)     return ev ? CNT_W'(1) : '0;
    else if (ev) return (&cnt) ? cnt : cnt + CNT_W'(1);
    else         return cnt;
  endfunction

  // Clamp the requested data length into the supported range.
  always_comb begin
    if (bus.data_len < LEN_W'(LEN_MIN))       eff_len_c = BCW'(LEN_MIN);
    else if (bus.data_len > LEN_W'(DATA_MAX)) eff_len_c = BCW'(DATA_MAX);
    else                                      eff_len_c = BCW'(bus.data_len);
  end

  // Expected parity bit from the latched mode and running data XOR.
  always_comb begin
    unique case (par_mode_q)
      2'b00:   exp_par_c = acc_q;
      2'b01:   exp_par_c = ~acc_q;
      2'b10:   exp_par_c = 1'b1;
      default: exp_par_c = 1'b0;
    endcase
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    par_en_d    = par_en_q;
    par_mode_d  = par_mode_q;
    stop2_d     = stop2_q;
    acc_d       = acc_q;
    par_bad_d   = par_bad_q;
    stop_bad_d  = stop_bad_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    par_err_d   = 1'b0;
    stop_err_d  = 1'b0;
    last_stop_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_det) begin
          state_d    = S_DATA;
          par_en_d   = bus.par_en;
          par_mode_d = bus.par_mode;
          stop2_d    = bus.stop2;
          len_d      = eff_len_c;
          shift_d    = '0;
          cnt_d      = '0;
          acc_d      = 1'b0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bus.bit_stb) begin
          for (int i = 0; i < DATA_MAX; i++) begin
            if (BCW'(i) == cnt_q) shift_d[i] = bus.sampled_bit;
          end
          acc_d = acc_q ^ bus.sampled_bit;
          cnt_d = cnt_q + BCW'(1);
          if (cnt_d == len_q) state_d = par_en_q ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (bus.bit_stb) begin
          par_bad_d = bus.sampled_bit ^ exp_par_c;
          state_d   = S_STOP1;
        end
      end
      S_STOP1: begin
        if (bus.bit_stb) begin
          stop_bad_d = stop_bad_q | ~bus.sampled_bit;
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d     = S_DONE;
            last_stop_c = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (bus.bit_stb) begin
          stop_bad_d  = stop_bad_q | ~bus.sampled_bit;
          state_d     = S_DONE;
          last_stop_c = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Frame results are registered so they are visible during DONE.
    if (last_stop_c) begin
      rx_valid_d = 1'b1;
      par_err_d  = par_bad_q;
      stop_err_d = stop_bad_d;
      rx_data_d  = shift_q;
    end
    sticky_par_d  = bus.err_clr ? par_err_q  : (sticky_par_q  | par_err_q);
    sticky_stop_d = bus.err_clr ? stop_err_q : (sticky_stop_q | stop_err_q);
    par_cnt_d     = next_cnt(par_cnt_q,  par_err_q,  bus.err_clr);
    stop_cnt_d    = next_cnt(stop_cnt_q, stop_err_q, bus.err_clr);
    busy_d        = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      par_en_q      <= 1'b0;
      par_mode_q    <= 2'b00;
      stop2_q       <= 1'b0;
      acc_q         <= 1'b0;
      par_bad_q     <= 1'b0;
      stop_bad_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      par_err_q     <= 1'b0;
      stop_err_q    <= 1'b0;
      sticky_par_q  <= 1'b0;
      sticky_stop_q <= 1'b0;
      par_cnt_q     <= '0;
      stop_cnt_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      par_en_q      <= par_en_d;
      par_mode_q    <= par_mode_d;
      stop2_q       <= stop2_d;
      acc_q         <= acc_d;
      par_bad_q     <= par_bad_d;
      stop_bad_q    <= stop_bad_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      par_err_q     <= par_err_d;
      stop_err_q    <= stop_err_d;
      sticky_par_q  <= sticky_par_d;
      sticky_stop_q <= sticky_stop_d;
      par_cnt_q     <= par_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rx_data         = rx_data_q;
  assign bus.rx_valid        = rx_valid_q;
  assign bus.par_err         = par_err_q;
  assign bus.stop_err        = stop_err_q;
  assign bus.sticky_par_err  = sticky_par_q;
  assign bus.sticky_stop_err = sticky_stop_q;
  assign bus.par_err_cnt     = par_cnt_q;
  assign bus.stop_err_cnt    = stop_cnt_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: directed frames then random frames against a
// frame-level reference model; a second instance with 2-bit counters shares stimulus.
module tb_uart_rx_frame_check;
  localparam int unsigned DATA_MAX = 9;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CNT_W2   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_check_if #(.DATA_MAX(DATA_MAX), .LEN_W(LEN_W), .CNT_W(CNT_W))  bus ();
  uart_rx_frame_check_if #(.DATA_MAX(DATA_MAX), .LEN_W(LEN_W), .CNT_W(CNT_W2)) bus2 ();

  uart_rx_frame_check #(.DATA_MAX(DATA_MAX), .LEN_W(LEN_W), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  uart_rx_frame_check #(.DATA_MAX(DATA_MAX), .LEN_W(LEN_W), .CNT_W(CNT_W2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.start_det   = bus.start_det;
  assign bus2.bit_stb     = bus.bit_stb;
  assign bus2.sampled_bit = bus.sampled_bit;
  assign bus2.par_en      = bus.par_en;
  assign bus2.par_mode    = bus.par_mode;
  assign bus2.data_len    = bus.data_len;
  assign bus2.stop2       = bus.stop2;
  assign bus2.err_clr     = bus.err_clr;

  int errors = 0;
  int checks = 0;
  int valid_seen = 0;
  int valid_exp = 0;

  // Reference model state
  logic [8:0] m_data;
  logic m_sp, m_ss, m_sp2, m_ss2;
  int   m_pc, m_sc, m_pc2, m_sc2;

  always @(negedge clk) if (bus.rx_valid === 1'b1) valid_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int dl);
    if (dl < 5) return 5;
    if (dl > int'(DATA_MAX)) return int'(DATA_MAX);
    return dl;
  endfunction

  function automatic logic exp_par(input logic [1:0] pm, input logic [8:0] d, input int len);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(d[i]);
    case (pm)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic upd(input logic e, input logic clr, input int maxv,
                     inout logic st, inout int c);
    if (clr) begin
      st = e;
      c  = e ? 1 : 0;
    end else if (e) begin
      st = 1'b1;
      if (c < maxv) c++;
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    m_sp = 0; m_ss = 0; m_sp2 = 0; m_ss2 = 0;
    m_pc = 0; m_sc = 0; m_pc2 = 0; m_sc2 = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid0"}, 32'(bus.rx_valid), 32'(0));
    chk({tag, "_perr0"},  32'(bus.par_err), 32'(0));
    chk({tag, "_serr0"},  32'(bus.stop_err), 32'(0));
    chk({tag, "_busy0"},  32'(bus.busy), 32'(0));
    chk({tag, "_hold"},   32'(bus.rx_data), 32'(m_data));
    chk({tag, "_stkp"},   32'(bus.sticky_par_err), 32'(m_sp));
    chk({tag, "_stks"},   32'(bus.sticky_stop_err), 32'(m_ss));
    chk({tag, "_pcnt"},   32'(bus.par_err_cnt), 32'(m_pc));
    chk({tag, "_scnt"},   32'(bus.stop_err_cnt), 32'(m_sc));
    chk({tag, "_stkp2"},  32'(bus2.sticky_par_err), 32'(m_sp2));
    chk({tag, "_stks2"},  32'(bus2.sticky_stop_err), 32'(m_ss2));
    chk({tag, "_pcnt2"},  32'(bus2.par_err_cnt), 32'(m_pc2));
    chk({tag, "_scnt2"},  32'(bus2.stop_err_cnt), 32'(m_sc2));
  endtask

  task automatic scramble_cfg();
    bus.par_en   = 1'($urandom);
    bus.par_mode = 2'($urandom);
    bus.data_len = LEN_W'($urandom);
    bus.stop2    = 1'($urandom);
  endtask

  task automatic send_frame(input logic pe, input logic [1:0] pm, input int dl, input logic s2,
                            input logic [8:0] d, input logic pbit, input logic sb1,
                            input logic sb2, input logic clr_done, input logic noise,
                            input string tag);
    int len;
    logic bits[$];
    logic [8:0] exp_d;
    logic e_p, e_s;
    len   = eff_len(dl);
    exp_d = '0;
    for (int i = 0; i < len; i++) begin
      exp_d[i] = d[i];
      bits.push_back(d[i]);
    end
    if (pe) bits.push_back(pbit);
    bits.push_back(sb1);
    if (s2) bits.push_back(sb2);
    e_p = pe && (pbit != exp_par(pm, d, len));
    e_s = !sb1 || (s2 && !sb2);

    bus.par_en      = pe;
    bus.par_mode    = pm;
    bus.data_len    = LEN_W'(dl);
    bus.stop2       = s2;
    bus.start_det   = 1'b1;
    bus.bit_stb     = noise ? 1'($urandom) : 1'b0;
    bus.sampled_bit = 1'($urandom);
    tick();
    bus.start_det = 1'b0;
    bus.bit_stb   = 1'b0;
    chk({tag, "_busy1"}, 32'(bus.busy), 32'(1));

    for (int k = 0; k < bits.size(); k++) begin
      repeat ($urandom_range(0, 2)) begin
        if (noise) begin
          bus.start_det = 1'($urandom);
          scramble_cfg();
        end
        tick();
        bus.start_det = 1'b0;
      end
      if (noise) bus.start_det = 1'($urandom);
      bus.bit_stb     = 1'b1;
      bus.sampled_bit = bits[k];
      tick();
      bus.bit_stb   = 1'b0;
      bus.start_det = 1'b0;
      if (k < bits.size() - 1) chk({tag, "_early"}, 32'(bus.rx_valid), 32'(0));
    end

    chk({tag, "_valid"}, 32'(bus.rx_valid), 32'(1));
    chk({tag, "_data"},  32'(bus.rx_data), 32'(exp_d));
    chk({tag, "_perr"},  32'(bus.par_err), 32'(e_p));
    chk({tag, "_serr"},  32'(bus.stop_err), 32'(e_s));
    chk({tag, "_busyd"}, 32'(bus.busy), 32'(1));
    m_data = exp_d;
    valid_exp++;

    bus.err_clr = clr_done;
    if (noise) begin
      bus.start_det = 1'($urandom);
      bus.bit_stb   = 1'($urandom);
    end
    tick();
    bus.err_clr   = 1'b0;
    bus.start_det = 1'b0;
    bus.bit_stb   = 1'b0;
    upd(e_p, clr_done, 255, m_sp,  m_pc);
    upd(e_s, clr_done, 255, m_ss,  m_sc);
    upd(e_p, clr_done, 3,   m_sp2, m_pc2);
    upd(e_s, clr_done, 3,   m_ss2, m_sc2);
    check_idle(tag);
  endtask

  initial begin
    bus.start_det = 0; bus.bit_stb = 0; bus.sampled_bit = 0;
    bus.par_en = 0; bus.par_mode = 0; bus.data_len = 0;
    bus.stop2 = 0; bus.err_clr = 0;
    model_reset();
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // bit_stb while idle is not data
    repeat (4) begin
      bus.bit_stb = 1'($urandom);
      bus.sampled_bit = 1'($urandom);
      tick();
    end
    bus.bit_stb = 0;
    check_idle("idle_stb");

    send_frame(1, 2'd0, 8, 0, 9'h0A5, 0, 1, 1, 0, 0, "8E1");
    send_frame(1, 2'd1, 8, 0, 9'h0A5, 0, 1, 1, 0, 0, "8O1_bad");
    send_frame(1, 2'd1, 8, 0, 9'h0A5, 1, 1, 1, 0, 0, "8O1_ok");
    send_frame(0, 2'd0, 7, 1, 9'h041, 0, 1, 0, 0, 0, "7N2_stop");
    send_frame(0, 2'd0, 3, 0, 9'h015, 0, 1, 1, 0, 0, "len3");
    send_frame(0, 2'd0, 12, 0, 9'h1C3, 0, 1, 1, 0, 0, "len12");
    send_frame(1, 2'd2, 9, 0, 9'h1FF, 1, 1, 1, 0, 0, "9M_ok");
    send_frame(1, 2'd2, 9, 0, 9'h1FF, 0, 1, 1, 1, 0, "9M_clr");
    send_frame(1, 2'd3, 6, 1, 9'h02D, 0, 1, 1, 0, 0, "6S2");
    for (int n = 0; n < 5; n++)
      send_frame(0, 2'd0, 5, 0, 9'($urandom), 0, 0, 1, 0, 0, "sat");

    // standalone clear
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    m_sp = 0; m_ss = 0; m_sp2 = 0; m_ss2 = 0;
    m_pc = 0; m_sc = 0; m_pc2 = 0; m_sc2 = 0;
    check_idle("errclr");

    // reset in the middle of a frame
    send_frame(1, 2'd1, 8, 0, 9'h0F0, 0, 0, 1, 0, 0, "pre_rst");
    bus.par_en = 0; bus.data_len = LEN_W'(8); bus.stop2 = 0;
    bus.start_det = 1'b1;
    tick();
    bus.start_det = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.bit_stb = 1'b1;
      bus.sampled_bit = 1'($urandom);
      tick();
    end
    bus.bit_stb = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    check_idle("midrst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_idle("postrst");

    send_frame(0, 2'd0, 8, 0, 9'h03C, 0, 1, 1, 0, 1, "8N1_3C");

    for (int n = 0; n < 40; n++) begin
      logic pe, s2;
      logic [1:0] pm;
      int dl;
      logic [8:0] d;
      logic pb;
      pe = 1'($urandom);
      pm = 2'($urandom);
      dl = int'($urandom_range(0, 15));
      s2 = 1'($urandom);
      d  = 9'($urandom);
      pb = exp_par(pm, d, eff_len(dl)) ^ ($urandom_range(0, 3) == 0);
      send_frame(pe, pm, dl, s2, d, pb, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
                 1'($urandom), "rand");
    end

    chk("valid_count", 32'(valid_seen), 32'(valid_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
